// File: rtl/golomb_pkg.sv
// Shared types and sizing helpers for the Golomb bit packer.
package golomb_pkg;

    typedef enum logic [0:0] {StFill, StFlush} state_e;

    function automatic int unsigned buffer_width(input int unsigned output_width,
                                                 input int unsigned code_width);
        return output_width + code_width - 1;
    endfunction

    // Counter must represent 0..buffer_width inclusive.
    function automatic int unsigned cnt_width(input int unsigned buf_width);
        return $clog2(buf_width + 1);
    endfunction

endpackage

// File: rtl/golomb_bit_packer_if.sv
// Codeword input stream plus packed-word output stream of the Golomb bit packer.
interface golomb_bit_packer_if #(
    parameter int unsigned CODE_WIDTH        = 39,
    parameter int unsigned CODE_LENGTH_WIDTH = 6,
    parameter int unsigned OUTPUT_WIDTH      = 32
);
    logic [CODE_WIDTH-1:0]        input_code;
    logic [CODE_LENGTH_WIDTH-1:0] input_length;
    logic                         input_ends_input;
    logic                         input_valid;
    logic                         input_ready;
    logic [OUTPUT_WIDTH-1:0]      output_data;
    logic                         output_last;
    logic                         output_valid;
    logic                         output_ready;

    modport master (
        output input_code, input_length, input_ends_input, input_valid, output_ready,
        input  input_ready, output_data, output_last, output_valid
    );

    modport slave (
        input  input_code, input_length, input_ends_input, input_valid, output_ready,
        output input_ready, output_data, output_last, output_valid
    );
endinterface

// File: rtl/code_aligner.sv
// Clamps and masks a right-aligned codeword, then places it just below the
// cnt bits already held in the MSB-aligned buffer.
module code_aligner #(
    parameter int unsigned CODE_WIDTH        = 39,
    parameter int unsigned CODE_LENGTH_WIDTH = 6,
    parameter int unsigned BUFFER_WIDTH      = 70,
    parameter int unsigned CNT_WIDTH         = 7
) (
    input  logic [CODE_WIDTH-1:0]        code,
    input  logic [CODE_LENGTH_WIDTH-1:0] length,
    input  logic [CNT_WIDTH-1:0]         cnt,
    output logic [CNT_WIDTH-1:0]         length_clamped,
    output logic [BUFFER_WIDTH-1:0]      aligned
);
    logic [CODE_WIDTH-1:0] masked;
    logic [CNT_WIDTH-1:0]  shamt;

    always_comb begin
        if (int'(length) > int'(CODE_WIDTH)) begin
            length_clamped = CNT_WIDTH'(CODE_WIDTH);
        end else begin
            length_clamped = CNT_WIDTH'(length);
        end
        masked = '0;
        for (int i = 0; i < int'(CODE_WIDTH); i++) begin
            masked[i] = code[i] & (i < int'(length_clamped));
        end
        // Only meaningful while cnt < OUTPUT_WIDTH, which keeps this non-negative.
        shamt   = CNT_WIDTH'(BUFFER_WIDTH) - cnt - length_clamped;
        aligned = {{(BUFFER_WIDTH - CODE_WIDTH){1'b0}}, masked} << shamt;
    end
endmodule

// File: rtl/golomb_bit_packer.sv
// Packs variable-length codewords into MSB-first fixed-width words, flushing a
// zero-padded final word tagged last at end of segment.
module golomb_bit_packer
    import golomb_pkg::*;
#(
    parameter int unsigned CODE_WIDTH        = 39,
    parameter int unsigned CODE_LENGTH_WIDTH = 6,
    parameter int unsigned OUTPUT_WIDTH      = 32
) (
    input logic               clk,
    input logic               rst,
    golomb_bit_packer_if.slave bus
);
    localparam int unsigned BUFFER_WIDTH = buffer_width(OUTPUT_WIDTH, CODE_WIDTH);
    localparam int unsigned CNT_WIDTH    = cnt_width(BUFFER_WIDTH);
    localparam logic [CNT_WIDTH-1:0] OutCnt = CNT_WIDTH'(OUTPUT_WIDTH);

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [BUFFER_WIDTH-1:0] buf_q, buf_d;

    logic [CNT_WIDTH-1:0]    len_clamped;
    logic [BUFFER_WIDTH-1:0] aligned;
    logic                    in_ready, out_valid, out_last, in_fire, out_fire;

    code_aligner #(
        .CODE_WIDTH       (CODE_WIDTH),
        .CODE_LENGTH_WIDTH(CODE_LENGTH_WIDTH),
        .BUFFER_WIDTH     (BUFFER_WIDTH),
        .CNT_WIDTH        (CNT_WIDTH)
    ) u_code_aligner (
        .code          (bus.input_code),
        .length        (bus.input_length),
        .cnt           (cnt_q),
        .length_clamped(len_clamped),
        .aligned       (aligned)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;

        unique case (state_q)
            StFill: begin
                in_ready  = rst && (cnt_q < OutCnt);
                out_valid = (cnt_q >= OutCnt);
            end
            StFlush: begin
                out_valid = 1'b1;
                out_last  = (cnt_q <= OutCnt);
            end
            default: ;
        endcase

        in_fire  = in_ready && bus.input_valid;
        out_fire = out_valid && bus.output_ready;

        if (in_fire) begin
            buf_d = buf_q | aligned;
            cnt_d = cnt_q + len_clamped;
            if (bus.input_ends_input) begin
                state_d = StFlush;
            end
        end else if (out_fire) begin
            if (out_last) begin
                buf_d   = '0;
                cnt_d   = '0;
                state_d = StFill;
            end else begin
                buf_d = buf_q << OUTPUT_WIDTH;
                cnt_d = cnt_q - OutCnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFill;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    assign bus.input_ready  = in_ready;
    assign bus.output_valid = out_valid;
    assign bus.output_last  = out_last;
    assign bus.output_data  = buf_q[BUFFER_WIDTH-1 -: OUTPUT_WIDTH];
endmodule

// File: tb/tb_golomb_bit_packer.sv
// Random and directed bench for golomb_bit_packer, checked against a bit-queue model.
module tb_golomb_bit_packer;
    localparam int CW = 39;
    localparam int LW = 6;
    localparam int OW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    golomb_bit_packer_if #(.CODE_WIDTH(CW), .CODE_LENGTH_WIDTH(LW), .OUTPUT_WIDTH(OW)) bus();

    golomb_bit_packer #(.CODE_WIDTH(CW), .CODE_LENGTH_WIDTH(LW), .OUTPUT_WIDTH(OW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: pending stream bits, oldest first, plus flush mode.
    bit q[$];
    bit flushing = 1'b0;

    logic [OW-1:0] log_data[$];
    logic          log_last[$];

    bit hold_low  = 1'b0;
    bit rand_rdy  = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Single compare process: model prediction vs DUT every cycle, then model update.
    always @(negedge clk) begin
        bit            exp_ready, exp_valid, exp_last;
        logic [OW-1:0] exp_data;
        int            len;
        if (!rst) begin
            q.delete();
            flushing = 1'b0;
            check("reset_input_ready", 64'(bus.input_ready), 64'd0);
            check("reset_output_valid", 64'(bus.output_valid), 64'd0);
            check("reset_output_data", 64'(bus.output_data), 64'd0);
        end else begin
            exp_ready = !flushing && (q.size() < OW);
            exp_valid = flushing || (q.size() >= OW);
            exp_last  = flushing && (q.size() <= OW);
            for (int i = 0; i < OW; i++) exp_data[OW-1-i] = (i < q.size()) ? q[i] : 1'b0;
            check("input_ready", 64'(bus.input_ready), 64'(exp_ready));
            check("output_valid", 64'(bus.output_valid), 64'(exp_valid));
            if (exp_valid) begin
                check("output_data", 64'(bus.output_data), 64'(exp_data));
                check("output_last", 64'(bus.output_last), 64'(exp_last));
            end
            if (bus.output_valid && bus.output_ready) begin
                log_data.push_back(bus.output_data);
                log_last.push_back(bus.output_last);
            end
            if (exp_ready && bus.input_valid) begin
                len = (int'(bus.input_length) > CW) ? CW : int'(bus.input_length);
                for (int i = len - 1; i >= 0; i--) q.push_back(bus.input_code[i]);
                if (bus.input_ends_input) flushing = 1'b1;
            end else if (exp_valid && bus.output_ready) begin
                if (exp_last) begin
                    q.delete();
                    flushing = 1'b0;
                end else begin
                    for (int i = 0; i < OW; i++) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        bus.output_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.output_ready = hold_low ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    task automatic send(input logic [CW-1:0] code, input logic [LW-1:0] len, input logic ends);
        int n = 0;
        bus.input_code       = code;
        bus.input_length     = len;
        bus.input_ends_input = ends;
        bus.input_valid      = 1'b1;
        @(negedge clk);
        while (!bus.input_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", 64'(n >= 300), 64'd0);
        @(posedge clk);
        #1;
        bus.input_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((q.size() != 0 || flushing || bus.output_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(n >= 500), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_log(input string name, input int idx, input logic [OW-1:0] d,
                              input logic l);
        check({name, "_present"}, 64'(idx < log_data.size()), 64'd1);
        if (idx < log_data.size()) begin
            check({name, "_data"}, 64'(log_data[idx]), 64'(d));
            check({name, "_last"}, 64'(log_last[idx]), 64'(l));
        end
    endtask

    initial begin
        int            base;
        logic [63:0]   r;
        logic [LW-1:0] len;

        bus.input_code       = '0;
        bus.input_length     = '0;
        bus.input_ends_input = 1'b0;
        bus.input_valid      = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_ready", 64'(bus.input_ready), 64'd0);
            check("rst_hold_valid", 64'(bus.output_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.input_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(bus.input_ready), 64'd1);
        check("post_rst_valid", 64'(bus.output_valid), 64'd0);
        @(posedge clk);
        #1;

        base = log_data.size();
        send(39'hA1, 6'd8, 1'b0);
        send(39'hB2, 6'd8, 1'b0);
        send(39'hC3, 6'd8, 1'b0);
        send(39'hD4, 6'd8, 1'b0);
        wait_idle();
        expect_log("aligned", base, 32'hA1B2C3D4, 1'b0);

        base = log_data.size();
        send({CW{1'b1}}, 6'd39, 1'b1);
        wait_idle();
        expect_log("spill0", base, 32'hFFFFFFFF, 1'b0);
        expect_log("spill1", base + 1, 32'hFE000000, 1'b1);

        base = log_data.size();
        send(39'h7F, 6'd3, 1'b1);
        wait_idle();
        expect_log("mask", base, 32'hE0000000, 1'b1);

        base = log_data.size();
        send(39'h40_0000_0081, 6'd50, 1'b1);
        wait_idle();
        expect_log("clamp0", base, 32'h80000001, 1'b0);
        expect_log("clamp1", base + 1, 32'h02000000, 1'b1);

        base = log_data.size();
        send(39'h1234, 6'd0, 1'b1);
        wait_idle();
        expect_log("empty", base, 32'h00000000, 1'b1);
        check("empty_count", 64'(log_data.size() - base), 64'd1);

        hold_low = 1'b1;
        send(39'hA1, 6'd8, 1'b0);
        send(39'hB2, 6'd8, 1'b0);
        send(39'hC3, 6'd8, 1'b0);
        send(39'hD4, 6'd8, 1'b0);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 64'(bus.output_valid), 64'd1);
            check("bp_data", 64'(bus.output_data), 64'hA1B2C3D4);
            check("bp_last", 64'(bus.output_last), 64'd0);
            check("bp_ready", 64'(bus.input_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        hold_low = 1'b0;
        wait_idle();

        hold_low = 1'b1;
        base = log_data.size();
        send({CW{1'b1}}, 6'd39, 1'b1);
        @(negedge clk);
        check("flush_pending", 64'(bus.output_valid), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        hold_low = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_flush_no_output", 64'(log_data.size() - base), 64'd0);
        @(posedge clk);
        #1;
        send(39'h7F, 6'd3, 1'b1);
        wait_idle();
        expect_log("after_rst", base, 32'hE0000000, 1'b1);

        rand_rdy = 1'b1;
        for (int k = 0; k < 400; k++) begin
            r = {$urandom, $urandom};
            len = ($urandom_range(0, 7) == 0) ? LW'($urandom_range(40, 63))
                                              : LW'($urandom_range(0, CW));
            send(r[CW-1:0], len, $urandom_range(0, 15) == 0);
        end
        send('0, 6'd0, 1'b1);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
